// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one common data bus among ADD, MUL and LD stations
module cdb_arbiter #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ADD_Req,
  input  logic              MUL_Req,
  input  logic              LD_Req,
  input  logic [TAG_W-1:0]  ADD_Tag,
  input  logic [TAG_W-1:0]  MUL_Tag,
  input  logic [TAG_W-1:0]  LD_Tag,
  input  logic [DATA_W-1:0] ADD_Result,
  input  logic [DATA_W-1:0] MUL_Result,
  input  logic [DATA_W-1:0] LD_Result,
  output logic              ADD_Grant,
  output logic              MUL_Grant,
  output logic              LD_Grant,
  output logic              CDB_Valid,
  output logic [TAG_W-1:0]  CDB_Tag,
  output logic [DATA_W-1:0] CDB_Data,
  output logic              Tag_Err,
  output logic [7:0]        Bcast_Count
);

  // Identity of the most recently granted station; encoding 3 is never produced.
  typedef enum logic [1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_LD  = 2'd2
  } src_e;

  src_e              last_q, last_d, win;
  logic              win_valid;
  logic [2:0]        req_v, tag_nz, elig;
  logic [2:0]        grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              terr_q, terr_d;
  logic [7:0]        cnt_q, cnt_d;

  // Eligibility: requesting, carrying a real tag, and not sitting in its own grant cycle.
  always_comb begin
    req_v  = {LD_Req, MUL_Req, ADD_Req};
    tag_nz = {(LD_Tag != '0), (MUL_Tag != '0), (ADD_Tag != '0)};
    elig   = req_v & tag_nz & ~grant_q;
  end

  // Round-robin pick: search starts at the station after the last winner.
  always_comb begin
    win_valid = 1'b0;
    win       = SRC_ADD;
    case (last_q)
      SRC_ADD: begin
        if (elig[1])      begin win = SRC_MUL; win_valid = 1'b1; end
        else if (elig[2]) begin win = SRC_LD;  win_valid = 1'b1; end
        else if (elig[0]) begin win = SRC_ADD; win_valid = 1'b1; end
      end
      SRC_MUL: begin
        if (elig[2])      begin win = SRC_LD;  win_valid = 1'b1; end
        else if (elig[0]) begin win = SRC_ADD; win_valid = 1'b1; end
        else if (elig[1]) begin win = SRC_MUL; win_valid = 1'b1; end
      end
      default: begin
        if (elig[0])      begin win = SRC_ADD; win_valid = 1'b1; end
        else if (elig[1]) begin win = SRC_MUL; win_valid = 1'b1; end
        else if (elig[2]) begin win = SRC_LD;  win_valid = 1'b1; end
      end
    endcase
  end

  // Next broadcast, grants, pointer, counter and sticky tag-error flag.
  always_comb begin
    valid_d = 1'b0;
    tag_d   = '0;
    data_d  = '0;
    grant_d = 3'b000;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q | (|(req_v & ~tag_nz));
    if (win_valid) begin
      valid_d = 1'b1;
      last_d  = win;
      cnt_d   = cnt_q + 8'd1;
      case (win)
        SRC_ADD: begin tag_d = ADD_Tag; data_d = ADD_Result; grant_d = 3'b001; end
        SRC_MUL: begin tag_d = MUL_Tag; data_d = MUL_Result; grant_d = 3'b010; end
        default: begin tag_d = LD_Tag;  data_d = LD_Result;  grant_d = 3'b100; end
      endcase
    end
  end

  // State register; reset leaves LD as last winner so ADD has first priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q  <= SRC_LD;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      grant_q <= 3'b000;
      terr_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ADD_Grant   = grant_q[0];
  assign MUL_Grant   = grant_q[1];
  assign LD_Grant    = grant_q[2];
  assign CDB_Valid   = valid_q;
  assign CDB_Tag     = tag_q;
  assign CDB_Data    = data_q;
  assign Tag_Err     = terr_q;
  assign Bcast_Count = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req;
  logic [TAG_W-1:0]  tag [3];
  logic [DATA_W-1:0] res [3];

  logic              add_grant, mul_grant, ld_grant, cdb_valid, tag_err;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [7:0]        bcast_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int       m_last;
  bit [2:0] m_grant;
  bit       m_valid, m_terr;
  int       m_tag, m_data, m_cnt;

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  tags;     // {ld, mul, add}
    logic [23:0] results;  // {ld, mul, add}
    logic        e_valid;
    logic [2:0]  e_tag;
    logic [7:0]  e_data;
    logic [2:0]  e_grant;  // {ld, mul, add}
    logic        e_terr;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(rst_n),
    .ADD_Req(req[0]), .MUL_Req(req[1]), .LD_Req(req[2]),
    .ADD_Tag(tag[0]), .MUL_Tag(tag[1]), .LD_Tag(tag[2]),
    .ADD_Result(res[0]), .MUL_Result(res[1]), .LD_Result(res[2]),
    .ADD_Grant(add_grant), .MUL_Grant(mul_grant), .LD_Grant(ld_grant),
    .CDB_Valid(cdb_valid), .CDB_Tag(cdb_tag), .CDB_Data(cdb_data),
    .Tag_Err(tag_err), .Bcast_Count(bcast_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural rules: eligible = req, nonzero tag, not granted last cycle; first eligible after last winner.
  task automatic model_update();
    bit [2:0] elig;
    int win;
    if (!rst_n) begin
      m_last = 2; m_grant = 0; m_valid = 0; m_tag = 0; m_data = 0; m_terr = 0; m_cnt = 0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      elig[i] = req[i] && (tag[i] != 0) && !m_grant[i];
      if (req[i] && tag[i] == 0) m_terr = 1;
    end
    win = -1;
    for (int k = 1; k <= 3; k++)
      if (win < 0 && elig[(m_last + k) % 3]) win = (m_last + k) % 3;
    m_grant = 0;
    if (win >= 0) begin
      m_valid = 1; m_tag = int'(tag[win]); m_data = int'(res[win]);
      m_grant[win] = 1; m_last = win; m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_valid = 0; m_tag = 0; m_data = 0;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] rq, input logic [8:0] tg, input logic [23:0] rs);
    rst_n = r; req = rq;
    tag[0] = tg[2:0]; tag[1] = tg[5:3]; tag[2] = tg[8:6];
    res[0] = rs[7:0]; res[1] = rs[15:8]; res[2] = rs[23:16];
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic check_model(input string pfx);
    chk({pfx, ".valid"}, int'(cdb_valid), int'(m_valid));
    chk({pfx, ".tag"},   int'(cdb_tag),   m_tag);
    chk({pfx, ".data"},  int'(cdb_data),  m_data);
    chk({pfx, ".grant"}, int'({ld_grant, mul_grant, add_grant}), int'(m_grant));
    chk({pfx, ".terr"},  int'(tag_err),   int'(m_terr));
    chk({pfx, ".cnt"},   int'(bcast_count), m_cnt);
  endtask

  task automatic add_vec(input logic r, input logic [2:0] rq, input logic [8:0] tg, input logic [23:0] rs,
                         input logic ev, input logic [2:0] et, input logic [7:0] ed,
                         input logic [2:0] eg, input logic ee, input logic [7:0] ec);
    vec_t v;
    v.rst_n = r; v.req = rq; v.tags = tg; v.results = rs;
    v.e_valid = ev; v.e_tag = et; v.e_data = ed; v.e_grant = eg; v.e_terr = ee; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [8:0]  tg3;
    logic [23:0] rs3;
    rst_n = 1'b0; req = 3'b000;
    for (int i = 0; i < 3; i++) begin tag[i] = '0; res[i] = '0; end
    tg3 = {3'd6, 3'd4, 3'd1};
    rs3 = 24'h33_22_11;

    // reset, single ADD broadcast, then idle
    add_vec(0, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 0, 0);
    add_vec(1, 3'b001, {3'd0,3'd0,3'd1}, 24'h1C, 1, 1, 8'h1C, 3'b001, 0, 1);
    add_vec(1, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 0, 1);
    // all three requesting continuously
    add_vec(0, 3'b111, tg3, rs3,                 0, 0, 8'h00, 3'b000, 0, 0);
    add_vec(1, 3'b111, tg3, rs3,                 1, 1, 8'h11, 3'b001, 0, 1);
    add_vec(1, 3'b111, tg3, rs3,                 1, 4, 8'h22, 3'b010, 0, 2);
    add_vec(1, 3'b111, tg3, rs3,                 1, 6, 8'h33, 3'b100, 0, 3);
    add_vec(1, 3'b111, tg3, rs3,                 1, 1, 8'h11, 3'b001, 0, 4);
    add_vec(1, 3'b111, tg3, rs3,                 1, 4, 8'h22, 3'b010, 0, 5);
    add_vec(1, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 0, 5);
    // MUL alone held high: alternate-cycle grants
    add_vec(1, 3'b010, {3'd0,3'd5,3'd0}, 24'h00_55_00, 1, 5, 8'h55, 3'b010, 0, 6);
    add_vec(1, 3'b010, {3'd0,3'd5,3'd0}, 24'h00_55_00, 0, 0, 8'h00, 3'b000, 0, 6);
    add_vec(1, 3'b010, {3'd0,3'd5,3'd0}, 24'h00_55_00, 1, 5, 8'h55, 3'b010, 0, 7);
    add_vec(1, 3'b010, {3'd0,3'd5,3'd0}, 24'h00_55_00, 0, 0, 8'h00, 3'b000, 0, 7);
    add_vec(1, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 0, 7);
    // LD with tag 0: ignored, sticky error
    add_vec(1, 3'b100, 9'd0, 24'h99_00_00,       0, 0, 8'h00, 3'b000, 1, 7);
    add_vec(1, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 1, 7);
    add_vec(1, 3'b001, {3'd0,3'd0,3'd2}, 24'h7E, 1, 2, 8'h7E, 3'b001, 1, 8);
    add_vec(0, 3'b000, 9'd0, 24'd0,              0, 0, 8'h00, 3'b000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string p;
      p = $sformatf("vec%0d", i);
      step(vecs[i].rst_n, vecs[i].req, vecs[i].tags, vecs[i].results);
      chk({p, ".valid"}, int'(cdb_valid), int'(vecs[i].e_valid));
      chk({p, ".tag"},   int'(cdb_tag),   int'(vecs[i].e_tag));
      chk({p, ".data"},  int'(cdb_data),  int'(vecs[i].e_data));
      chk({p, ".grant"}, int'({ld_grant, mul_grant, add_grant}), int'(vecs[i].e_grant));
      chk({p, ".terr"},  int'(tag_err),   int'(vecs[i].e_terr));
      chk({p, ".cnt"},   int'(bcast_count), int'(vecs[i].e_cnt));
    end

    // 256 ADD broadcasts (held request, granted every other edge) wrap the counter
    step(0, 3'b000, 9'd0, 24'd0);
    for (int i = 0; i < 512; i++) begin
      step(1, 3'b001, {3'd0,3'd0,3'd1}, {16'd0, 8'(i)});
      check_model("wrap");
      if (i == 509) chk("wrap.cnt255", int'(bcast_count), 255);
    end
    chk("wrap.cnt0", int'(bcast_count), 0);

    // reset asserted in a grant cycle, then ADD wins first despite MUL requesting
    step(1, 3'b011, {3'd0,3'd4,3'd1}, 24'h00_44_11);
    chk("rstgrant.valid", int'(cdb_valid), 1);
    step(0, 3'b011, {3'd0,3'd4,3'd1}, 24'h00_44_11);
    chk("rst.valid", int'(cdb_valid), 0);
    chk("rst.grant", int'({ld_grant, mul_grant, add_grant}), 0);
    chk("rst.tagdata", int'({cdb_tag, cdb_data}), 0);
    chk("rst.cnt", int'(bcast_count), 0);
    step(1, 3'b011, {3'd0,3'd4,3'd1}, 24'h00_44_11);
    chk("rel.add_grant", int'(add_grant), 1);
    chk("rel.mul_grant", int'(mul_grant), 0);
    chk("rel.tag", int'(cdb_tag), 1);
    chk("rel.data", int'(cdb_data), 8'h11);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) != 0), 3'($urandom),
           {3'($urandom), 3'($urandom), 3'($urandom)}, 24'($urandom));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
